sprite_line_scheduler: RTL and testbench

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

---
 rtl/sprite_line_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans the attribute RAM once per line and publishes
// up to SLOTS visible sprites (front-most first) into a double-buffered output list.
module sprite_line_scheduler #(
    parameter int MAX_SPRITES = 8,
    parameter int SLOTS       = 4,
    localparam int IW         = $clog2(MAX_SPRITES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [9:0]            next_y,
    input  logic                  cpu_wr_req,
    output logic                  ram_rd_en,
    output logic [IW-1:0]         ram_rd_idx,
    input  logic [9:0]            ram_y,
    input  logic [4:0]            ram_h,
    input  logic                  ram_en,
    output logic [SLOTS-1:0]      slot_valid,
    output logic [SLOTS*IW-1:0]   slot_idx,
    output logic [SLOTS*4-1:0]    slot_row,
    output logic                  list_ready,
    output logic                  late,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

    state_t state_q, state_d;

    logic [9:0]          ly_q, ly_d;
    logic [IW-1:0]       index_q, index_d;
    logic [CW-1:0]       count_q, count_d;
    logic [SLOTS-1:0]    stg_valid_q, stg_valid_d;
    logic [SLOTS*IW-1:0] stg_idx_q, stg_idx_d;
    logic [SLOTS*4-1:0]  stg_row_q, stg_row_d;
    logic                stg_ovf_q, stg_ovf_d;
    logic [SLOTS-1:0]    out_valid_q, out_valid_d;
    logic [SLOTS*IW-1:0] out_idx_q, out_idx_d;
    logic [SLOTS*4-1:0]  out_row_q, out_row_d;
    logic                out_ovf_q, out_ovf_d;
    logic                list_ready_q, list_ready_d;
    logic                late_q, late_d;

    logic signed [10:0]  diff;
    logic [4:0]          h_lim;
    logic                hit;

    // Sprites taller than 16 lines are clipped; a negative diff means the sprite starts below the line.
    always_comb begin
        diff  = $signed({1'b0, ly_q}) - $signed({1'b0, ram_y});
        h_lim = (ram_h > 5'd16) ? 5'd16 : ram_h;
        hit   = ram_en && (diff >= 11'sd0) && (diff < $signed({6'd0, h_lim}));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_start) state_d = READ;
            READ:    if (line_start) state_d = READ;
                     else if (!cpu_wr_req) state_d = CHECK;
            CHECK:   if (line_start) state_d = READ;
                     else if (index_q == LAST_IDX) state_d = DONE;
                     else state_d = READ;
            DONE:    state_d = line_start ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_rd_en  = (state_q == READ) && !cpu_wr_req;
        ram_rd_idx = index_q;
        busy       = (state_q != IDLE);
    end

    always_comb begin
        ly_d         = ly_q;
        index_d      = index_q;
        count_d      = count_q;
        stg_valid_d  = stg_valid_q;
        stg_idx_d    = stg_idx_q;
        stg_row_d    = stg_row_q;
        stg_ovf_d    = stg_ovf_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_row_d    = out_row_q;
        out_ovf_d    = out_ovf_q;
        list_ready_d = 1'b0;
        late_d       = 1'b0;

        // Publication reads the staging registers before any restart below clears them.
        if (state_q == DONE) begin
            out_valid_d  = stg_valid_q;
            out_idx_d    = stg_idx_q;
            out_row_d    = stg_row_q;
            out_ovf_d    = stg_ovf_q;
            list_ready_d = 1'b1;
        end

        if (line_start) begin
            late_d      = (state_q == READ) || (state_q == CHECK);
            ly_d        = next_y;
            index_d     = '0;
            count_d     = '0;
            stg_valid_d = '0;
            stg_idx_d   = '0;
            stg_row_d   = '0;
            stg_ovf_d   = 1'b0;
        end else if (state_q == CHECK) begin
            if (hit) begin
                if (count_q < CW'(SLOTS)) begin
                    for (int k = 0; k < SLOTS; k++) begin
                        if (count_q == CW'(k)) begin
                            stg_valid_d[k]          = 1'b1;
                            stg_idx_d[k*IW +: IW]   = index_q;
                            stg_row_d[k*4 +: 4]     = diff[3:0];
                        end
                    end
                    count_d = count_q + CW'(1);
                end else begin
                    stg_ovf_d = 1'b1;
                end
            end
            if (index_q != LAST_IDX) index_d = index_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ly_q         <= '0;
            index_q      <= '0;
            count_q      <= '0;
            stg_valid_q  <= '0;
            stg_idx_q    <= '0;
            stg_row_q    <= '0;
            stg_ovf_q    <= 1'b0;
            out_valid_q  <= '0;
            out_idx_q    <= '0;
            out_row_q    <= '0;
            out_ovf_q    <= 1'b0;
            list_ready_q <= 1'b0;
            late_q       <= 1'b0;
        end else begin
            ly_q         <= ly_d;
            index_q      <= index_d;
            count_q      <= count_d;
            stg_valid_q  <= stg_valid_d;
            stg_idx_q    <= stg_idx_d;
            stg_row_q    <= stg_row_d;
            stg_ovf_q    <= stg_ovf_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_row_q    <= out_row_d;
            out_ovf_q    <= out_ovf_d;
            list_ready_q <= list_ready_d;
            late_q       <= late_d;
        end
    end

    assign slot_valid = out_valid_q;
    assign slot_idx   = out_idx_q;
    assign slot_row   = out_row_q;
    assign overflow   = out_ovf_q;
    assign list_ready = list_ready_q;
    assign late       = late_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: directed lines queue expected lists,
// a negedge monitor checks each list_ready/late pulse against the queues.
module tb_sprite_line_scheduler;

    localparam int MS = 8;
    localparam int SL = 4;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             line_start = 1'b0;
    logic [9:0]       next_y = '0;
    logic             cpu_wr_req = 1'b0;
    logic             ram_rd_en;
    logic [IW-1:0]    ram_rd_idx;
    logic [9:0]       ram_y = '0;
    logic [4:0]       ram_h = '0;
    logic             ram_en = 1'b0;
    logic [SL-1:0]    slot_valid;
    logic [SL*IW-1:0] slot_idx;
    logic [SL*4-1:0]  slot_row;
    logic             list_ready, late, overflow, busy;

    sprite_line_scheduler #(.MAX_SPRITES(MS), .SLOTS(SL)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .next_y(next_y),
        .cpu_wr_req(cpu_wr_req), .ram_rd_en(ram_rd_en), .ram_rd_idx(ram_rd_idx),
        .ram_y(ram_y), .ram_h(ram_h), .ram_en(ram_en),
        .slot_valid(slot_valid), .slot_idx(slot_idx), .slot_row(slot_row),
        .list_ready(list_ready), .late(late), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Attribute RAM model with one-cycle read latency
    logic [9:0] m_y  [MS];
    logic [4:0] m_h  [MS];
    logic       m_en [MS];

    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_y  <= m_y[ram_rd_idx];
            ram_h  <= m_h[ram_rd_idx];
            ram_en <= m_en[ram_rd_idx];
        end
    end

    typedef struct {
        logic [3:0]  v;
        logic [11:0] idx;
        logic [15:0] row;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   late_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   lr_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] v, input logic [11:0] idx, input logic [15:0] row,
                            input logic ovf, input int at);
        exp_t e;
        e.v = v; e.idx = idx; e.row = row; e.ovf = ovf; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic clear_ram();
        for (int i = 0; i < MS; i++) begin
            m_y[i] = '0; m_h[i] = '0; m_en[i] = 1'b0;
        end
    endtask

    task automatic set_spr(input int i, input logic [9:0] y, input logic [4:0] h, input logic en);
        m_y[i] = y; m_h[i] = h; m_en[i] = en;
    endtask

    task automatic pulse_start(input logic [9:0] y);
        line_start = 1'b1;
        next_y     = y;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_lists();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("list_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every list_ready / late pulse must match the head of its queue
    always @(negedge clk) begin
        if (list_ready) begin
            lr_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_list_ready", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("list_cycle", cyc, e.cyc);
                chk("slot_valid", slot_valid, e.v);
                chk("slot_idx", slot_idx, e.idx);
                chk("slot_row", slot_row, e.row);
                chk("overflow", overflow, e.ovf);
            end
        end
        if (late) begin
            if (late_q.size() == 0) begin
                chk("unexpected_late", 1, 0);
            end else begin
                int at;
                at = late_q.pop_front();
                chk("late_cycle", cyc, at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int lr_before;
        clear_ram();
        repeat (2) @(negedge clk);
        chk("rst_slot_valid", slot_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_list_ready", list_ready, 0);
        chk("rst_late", late, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        reset = 1'b0;
        @(negedge clk);

        // Two sprites covering line 105
        set_spr(0, 10'd100, 5'd16, 1'b1);
        set_spr(3, 10'd90, 5'd16, 1'b1);
        t0 = cyc;
        push_exp(4'b0011, 12'h018, 16'h00F5, 1'b0, t0 + 18);
        pulse_start(10'd105);
        chk("busy_eval", busy, 1);
        chk("rd_en_first_read", ram_rd_en, 1);
        chk("rd_idx_first_read", ram_rd_idx, 0);
        wait_lists();

        // Eight hits into four slots
        clear_ram();
        for (int i = 0; i < MS; i++) set_spr(i, 10'd50, 5'd8, 1'b1);
        t0 = cyc;
        push_exp(4'b1111, 12'h688, 16'h7777, 1'b1, t0 + 18);
        pulse_start(10'd57);
        wait_lists();
        t0 = cyc;
        push_exp(4'b0000, 12'h000, 16'h0000, 1'b0, t0 + 18);
        pulse_start(10'd58);
        repeat (5) @(negedge clk);
        chk("hold_valid_mid_eval", slot_valid, 4'hF);
        chk("hold_ovf_mid_eval", overflow, 1);
        wait_lists();

        // CPU write stalls READ for three cycles
        clear_ram();
        set_spr(0, 10'd100, 5'd16, 1'b1);
        set_spr(3, 10'd90, 5'd16, 1'b1);
        t0 = cyc;
        push_exp(4'b0011, 12'h018, 16'h00F5, 1'b0, t0 + 21);
        pulse_start(10'd105);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            cpu_wr_req = 1'b1;
            #1;
            chk("stall_rd_en", ram_rd_en, 0);
        end
        @(negedge clk);
        cpu_wr_req = 1'b0;
        #1;
        chk("post_stall_rd_en", ram_rd_en, 1);
        chk("post_stall_rd_idx", ram_rd_idx, 0);
        wait_lists();

        // Abort by a second line_start mid-evaluation
        set_spr(5, 10'd195, 5'd16, 1'b1);
        pulse_start(10'd105);
        repeat (9) @(negedge clk);
        t1 = cyc;
        late_q.push_back(t1 + 1);
        push_exp(4'b0001, 12'h005, 16'h0005, 1'b0, t1 + 18);
        pulse_start(10'd200);
        chk("late_hold_valid", slot_valid, 4'b0011);
        chk("late_hold_idx", slot_idx, 12'h018);
        wait_lists();
        chk("late_drained", late_q.size(), 0);

        // Clipped height, disabled entry, and line_start landing in DONE
        clear_ram();
        set_spr(0, 10'd982, 5'd20, 1'b1);
        set_spr(1, 10'd985, 5'd20, 1'b1);
        set_spr(2, 10'd1000, 5'd16, 1'b0);
        t0 = cyc;
        push_exp(4'b0001, 12'h001, 16'h000F, 1'b0, t0 + 18);
        pulse_start(10'd1000);
        repeat (16) @(negedge clk);
        t1 = cyc;
        push_exp(4'b0001, 12'h001, 16'h000F, 1'b0, t1 + 18);
        pulse_start(10'd1000);
        wait_lists();

        // No wrap at 1023, h=0, last row, one past last row, h=20
        clear_ram();
        set_spr(0, 10'd1020, 5'd16, 1'b1);
        set_spr(1, 10'd0, 5'd0, 1'b1);
        set_spr(2, 10'd0, 5'd4, 1'b1);
        set_spr(3, 10'd0, 5'd3, 1'b1);
        set_spr(4, 10'd0, 5'd20, 1'b1);
        t0 = cyc;
        push_exp(4'b0011, 12'h022, 16'h0033, 1'b0, t0 + 18);
        pulse_start(10'd3);
        wait_lists();

        // Reset mid-evaluation, second reset cycle also carries line_start
        pulse_start(10'd3);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_slot_valid", slot_valid, 0);
        chk("midrst_slot_idx", slot_idx, 0);
        chk("midrst_slot_row", slot_row, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_list_ready", list_ready, 0);
        chk("midrst_late", late, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", ram_rd_en, 0);
        line_start = 1'b1;
        next_y = 10'd3;
        @(negedge clk);
        reset = 1'b0;
        line_start = 1'b0;
        #1;
        chk("rst_over_start_busy", busy, 0);
        lr_before = lr_seen;
        repeat (30) @(negedge clk);
        chk("no_list_after_reset", lr_seen, lr_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
